mdu_iter: RTL and testbench

Iterative multiply/divide unit, WIDTH-parametrised, with a start/valid handshake. It is the multi-cycle companion to the single-cycle ALU in the EX stage. It produces a 2*WIDTH result on hi/lo for signed/unsigned multiply and divide. It supports a cancel for pipeline flush on exception.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_iter_if.sv | 37 +++
 rtl/mdu_step.sv | 44 ++++
 rtl/mdu_iter.sv | 137 +++++++++++++
 tb/tb_mdu_iter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
//   - FSM state type (IDLE, BUSY, DONE)
//   - helpers to classify an op as signed and/or divide
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result bundle between the EX stage and mdu_iter.
//   master (requester): drives start, op, opr1, opr2, cancel
//   slave  (mdu_iter) : drives busy, valid, hi, lo and the debug state
//
// Handshake: the requester raises start with op/opr1/opr2 stable and holds
// it until it sees busy=0; the unit accepts start only when not busy
// (IDLE or DONE) and when cancel is low. Starts seen while busy are dropped,
// not queued. valid is a one-cycle pulse in the cycle after the last
// iteration; hi/lo then hold that result until the next completion.
// cancel aborts an in-flight operation without touching hi/lo.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    import mdu_pkg::*;

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opr1;
    logic [WIDTH-1:0] opr2;
    logic             cancel;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    state_t           state;   // debug view of the control FSM

    modport master (
        output start, op, opr1, opr2, cancel,
        input  busy, valid, hi, lo, state
    );

    modport slave (
        input  start, op, opr1, opr2, cancel,
        output busy, valid, hi, lo, state
    );

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
//   mode     : 0 = multiply (radix-2 shift-add), 1 = divide (restoring)
//   acc      : running upper half (partial product / partial remainder)
//   sr       : operand shift register (multiplier bits / dividend -> quotient)
//   opr2_abs : magnitude of multiplier or divisor
//   acc_next, sr_next : values after this iteration
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sr,
    input  logic [WIDTH-1:0] opr2_abs,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] sr_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift {carry, acc, sr} right by one. After WIDTH steps
        // {acc, sr} holds the full product.
        sum = {1'b0, acc} + (sr[0] ? {1'b0, opr2_abs} : {(WIDTH+1){1'b0}});

        // Divide: bring the next dividend bit into the remainder and try the
        // subtraction. Remainder stays below the divisor, so the difference
        // fits in WIDTH bits whenever the subtraction is taken.
        shifted = {acc, sr[WIDTH-1]};
        fits    = (shifted >= {1'b0, opr2_abs});
        diff    = shifted[WIDTH-1:0] - opr2_abs;

        acc_next = sum[WIDTH:1];
        sr_next  = {sum[0], sr[WIDTH-1:1]};
        if (mode) begin
            acc_next = fits ? diff : shifted[WIDTH-1:0];
            sr_next  = {sr[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative signed/unsigned multiply and divide, one bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mdu_iter_if slave port (start/op/opr1/opr2/cancel in,
//              busy/valid/hi/lo/state out)
// Multiply: {hi,lo} = opr1 * opr2. Divide: lo = quotient, hi = remainder,
// truncating toward zero. Divide by zero gives lo = all ones, hi = opr1.
// Latency: accept in cycle T, valid in cycle T+WIDTH+1.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    mdu_iter_if.slave bus
);
    import mdu_pkg::*;

    localparam int CNTW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [CNTW-1:0]  cnt;
    logic             is_div_q;
    logic             neg_q;       // sign1 ^ sign2: negate product / quotient
    logic             rem_neg_q;   // sign1 on a signed divide: negate remainder
    logic             div_zero_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             last;
    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sr_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .mode     (is_div_q),
        .acc      (acc_q),
        .sr       (sr_q),
        .opr2_abs (b_q),
        .acc_next (acc_next),
        .sr_next  (sr_next)
    );

    // Operand magnitudes; only signed ops look at the sign bits.
    assign sign1 = is_signed(bus.op) & bus.opr1[WIDTH-1];
    assign sign2 = is_signed(bus.op) & bus.opr2[WIDTH-1];
    assign a_abs = sign1 ? (~bus.opr1 + 1'b1) : bus.opr1;
    assign b_abs = sign2 ? (~bus.opr2 + 1'b1) : bus.opr2;

    assign accept = (state != BUSY) && bus.start && !bus.cancel;
    assign last   = (cnt == CNTW'(WIDTH - 1));

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: begin
                if (bus.cancel)  state_next = IDLE;
                else if (last)   state_next = DONE;
            end
            DONE: state_next = accept ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign fix-up applied to the final iteration's output. A zero divisor
    // leaves the remainder equal to |opr1|, so restoring the dividend's sign
    // gives back opr1 exactly; only the quotient needs forcing.
    always_comb begin
        prod = {acc_next, sr_next};
        if (neg_q) prod = ~prod + 1'b1;
        hi_fix = prod[2*WIDTH-1:WIDTH];
        lo_fix = prod[WIDTH-1:0];
        if (is_div_q) begin
            hi_fix = rem_neg_q ? (~acc_next + 1'b1) : acc_next;
            lo_fix = div_zero_q ? {WIDTH{1'b1}}
                                : (neg_q ? (~sr_next + 1'b1) : sr_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            b_q        <= '0;
            acc_q      <= '0;
            sr_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt        <= '0;
                is_div_q   <= is_div(bus.op);
                neg_q      <= sign1 ^ sign2;
                rem_neg_q  <= sign1 & is_div(bus.op);
                div_zero_q <= (bus.opr2 == '0);
                b_q        <= b_abs;
                acc_q      <= '0;
                sr_q       <= a_abs;
            end else if (state == BUSY) begin
                if (bus.cancel) begin
                    cnt <= '0;
                end else begin
                    acc_q <= acc_next;
                    sr_q  <= sr_next;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        hi_q <= hi_fix;
                        lo_q <= lo_fix;
                    end
                end
            end
        end
    end

    assign bus.busy  = (state == BUSY);
    assign bus.valid = (state == DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.state = state;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter (WIDTH=32).
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns in cycle T+1 of the accept.
    task automatic drive_start(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opr1  = a;
        bus.opr2  = b;
        tick();
        bus.start = 1'b0;
    endtask

    // Called in cycle T+1; returns cycle index (relative to T) where valid
    // is seen, plus how many cycles busy was high on the way. Bounded.
    task automatic wait_valid(output int cyc, output int busy_cnt);
        cyc      = 1;
        busy_cnt = 0;
        while (!bus.valid && cyc < 100) begin
            if (bus.busy) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        n_tests++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
        n_tests++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    endtask

    task automatic test_mult_signed();
        int cyc, bc;
        drive_start(MDU_MULT, 32'hFFFFFFFD, 32'd7);
        wait_valid(cyc, bc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
        n_tests++; if (bc !== 32) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 32", bc); end
        n_tests++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", bus.hi); end
        n_tests++; if (bus.lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected ffffffeb", bus.lo); end
        tick();
        n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL mult_valid_pulse: got %b expected 0", bus.valid); end
        n_tests++; if (bus.lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo_hold: got %h expected ffffffeb", bus.lo); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        drive_start(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(cyc, bc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d expected 33", cyc); end
        n_tests++; if (bus.hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", bus.hi); end
        n_tests++; if (bus.lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", bus.lo); end
        // Start DIVU in the DONE cycle: must be busy the very next cycle.
        drive_start(MDU_DIVU, 32'd100, 32'd7);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", bus.busy); end
        n_tests++; if (bus.lo !== 32'h00000001) begin n_fail++; $display("FAIL b2b_lo_hold: got %h expected 00000001", bus.lo); end
        wait_valid(cyc, bc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", cyc); end
        n_tests++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h expected 2", bus.hi); end
        n_tests++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h expected 14", bus.lo); end
        tick();
    endtask

    task automatic test_div_signed();
        int cyc, bc;
        drive_start(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        wait_valid(cyc, bc);
        n_tests++; if (bus.lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", bus.lo); end
        n_tests++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", bus.hi); end
        tick();
        drive_start(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_valid(cyc, bc);
        n_tests++; if (bus.lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.lo); end
        n_tests++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 0", bus.hi); end
        tick();
    endtask

    task automatic test_div_zero();
        int cyc, bc;
        drive_start(MDU_DIVU, 32'h64, 32'h0);
        wait_valid(cyc, bc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL divu0_latency: got %0d expected 33", cyc); end
        n_tests++; if (bus.lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_lo: got %h expected ffffffff", bus.lo); end
        n_tests++; if (bus.hi !== 32'h64) begin n_fail++; $display("FAIL divu0_hi: got %h expected 64", bus.hi); end
        tick();
        drive_start(MDU_DIV, 32'hFFFFFFF9, 32'h0);
        wait_valid(cyc, bc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL div0_latency: got %0d expected 33", cyc); end
        n_tests++; if (bus.lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_lo: got %h expected ffffffff", bus.lo); end
        n_tests++; if (bus.hi !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL div0_hi: got %h expected fffffff9", bus.hi); end
        tick();
    endtask

    // Previous result here is hi=fffffff9, lo=ffffffff.
    task automatic test_cancel();
        int cyc, bc;
        int saw_valid;
        saw_valid = 0;
        drive_start(MDU_MULT, 32'd3, 32'd5);          // now in cycle 1
        for (int i = 1; i < 5; i++) begin
            if (bus.valid) saw_valid++;
            tick();
        end                                          // cycle 5
        bus.start = 1'b1; bus.opr1 = 32'd9; bus.opr2 = 32'd9;
        tick();                                      // cycle 6
        bus.start = 1'b0;
        for (int i = 6; i < 10; i++) begin
            if (bus.valid) saw_valid++;
            tick();
        end                                          // cycle 10
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_before: got %b expected 1", bus.busy); end
        bus.cancel = 1'b1;
        tick();                                      // cycle 11
        bus.cancel = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy_after: got %b expected 0", bus.busy); end
        n_tests++; if (saw_valid !== 0 || bus.valid !== 1'b0) begin n_fail++; $display("FAIL cancel_no_valid: got %0d/%b expected 0/0", saw_valid, bus.valid); end
        n_tests++; if (bus.hi !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL cancel_hi_hold: got %h expected fffffff9", bus.hi); end
        n_tests++; if (bus.lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL cancel_lo_hold: got %h expected ffffffff", bus.lo); end
        drive_start(MDU_MULT, 32'hFFFFFFFE, 32'hFFFFFFFE);
        wait_valid(cyc, bc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL after_cancel_latency: got %0d expected 33", cyc); end
        n_tests++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL after_cancel_hi: got %h expected 0", bus.hi); end
        n_tests++; if (bus.lo !== 32'd4) begin n_fail++; $display("FAIL after_cancel_lo: got %h expected 4", bus.lo); end
        tick();
    endtask

    task automatic test_mid_reset();
        int cyc, bc;
        drive_start(MDU_DIV, 32'd1000, 32'd3);        // cycle 1
        for (int i = 1; i < 20; i++) tick();          // cycle 20
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", bus.valid); end
        n_tests++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_fail++; $display("FAIL midrst_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
        drive_start(MDU_MULT, 32'd6, 32'd7);
        wait_valid(cyc, bc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL midrst_mult_latency: got %0d expected 33", cyc); end
        n_tests++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL midrst_mult_hi: got %h expected 0", bus.hi); end
        n_tests++; if (bus.lo !== 32'd42) begin n_fail++; $display("FAIL midrst_mult_lo: got %h expected 42", bus.lo); end
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = MDU_MULT;
        bus.opr1   = '0;
        bus.opr2   = '0;
        test_reset();
        test_mult_signed();
        test_back_to_back();
        test_div_signed();
        test_div_zero();
        test_cancel();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
